if_stage: RTL and testbench
===========================

// Module: if_stage
// PURPOSE
//   Instruction-fetch stage and IF/ID pipeline register. Owns the PC.
//   Fetches from a variable-latency instruction memory with a req/ack handshake.
//   Holds IF/ID on load-use stall and bubbles it on branch flush.
//   Its outputs feed decode/control, which produce the ID/EX register inputs.
// PARAMETERS
//   RESET_PC   32'h0000_0000  PC of first fetch after reset
//   NOP_INSTR  32'h0000_0013  bubble encoding (addi x0,x0,0)
// PORTS
//   clk                 in   1   clock, all state on posedge
//   rst_n               in   1   asynchronous, active-low reset
//   imem_req            out  1   fetch request; held with imem_addr until imem_ack
//   imem_addr           out  32  fetch address (word aligned)
//   imem_rdata          in   32  instruction, valid when imem_ack=1
//   imem_ack            in   1   one-cycle completion of the outstanding request
//   stall               in   1   hazard unit: hold IF/ID and PC
//   flush               in   1   EX: branch taken; redirect to branch_target
//   branch_target       in   32  redirect PC, sampled when flush=1
//   if_id_pc            out  32  PC of the instruction in IF/ID
//   if_id_instruction   out  32  instruction in IF/ID
//   if_id_valid         out  1   1 = real instruction, 0 = bubble
// BEHAVIOUR
//   Reset values (async, rst_n=0): pc=RESET_PC, state=START, if_id_pc=0,
//     if_id_instruction=NOP_INSTR, if_id_valid=0, imem_req=0.
//   imem_req=1 in FETCH and DRAIN only; imem_addr=pc in FETCH, old pc in DRAIN.
//   FSM states:
//   START: one idle cycle after reset release -> FETCH.
//   FETCH: request pc.
//     - ack & flush: discard data; pc<=branch_target; stay in FETCH.
//     - ack & !stall: IF/ID<={pc,rdata,1}; pc<=pc+4; stay in FETCH.
//     - ack & stall: capture rdata in hold_buf; go to HOLD.
//     - !ack & flush: save branch_target in redir; go to DRAIN.
//   HOLD: imem_req=0.
//     - flush: drop hold_buf; pc<=branch_target; go to FETCH.
//     - !stall: IF/ID<={pc,hold_buf,1}; pc<=pc+4; go to FETCH.
//   DRAIN: keep the old request until ack, because an outstanding request is never withdrawn.
//     - A later flush overwrites redir.
//     - ack: discard data; pc<=redir (or branch_target if flush this cycle); go to FETCH.
//   IF/ID update priority:
//     - flush: load bubble {0,NOP_INSTR,0}, including while stalled.
//     - else stall: hold IF/ID.
//     - else new instruction delivered: load it.
//     - else: load bubble.
//   Latency: the instruction is in IF/ID on the cycle after ack. At most one instruction is in flight.
//   PC arithmetic is 32-bit and wraps: 32'hFFFF_FFFC+4 -> 0.
//   branch_target[1:0] is ignored; it is forced to 2'b00.
//   Reset asserted mid-request: the FSM returns to START. The memory must drop any outstanding ack on reset.
// CONFIGURATION
//   IF_PERF_CNT_EN defined:
//     - Adds outputs perf_fetch_cnt[31:0] (+1 per IF/ID load with valid=1)
//       and perf_bubble_cnt[31:0] (+1 per IF/ID bubble load).
//     - Both counters are 32-bit saturating and reset to 0.
//   IF_PERF_CNT_EN undefined: the ports and counters do not exist. All other behaviour is identical.
// TESTING
//   1. Reset release, imem_ack 1 cycle after every req, data=32'h00A00093 ->
//      first IF/ID {pc=0,valid=1}; following PCs 4,8,C in consecutive accepts.
//   2. ack latency 3 cycles -> IF/ID bubbles (valid=0, NOP) in waiting cycles;
//      imem_addr stable through each wait.
//   3. stall=1 for 2 cycles coinciding with ack at pc=8 -> IF/ID holds pc=4;
//      the pc=8 instruction enters IF/ID the cycle after stall drops; no refetch of 8.
//   4. flush with target 32'h40 while request for pc=C is outstanding ->
//      DRAIN until ack, data discarded, next imem_addr=32'h40, IF/ID bubble.
//   5. flush and stall both high -> IF/ID loads a bubble (flush wins).
//      ack&flush in the same cycle -> next addr=target.
//   6. Reset asserted mid-DRAIN -> all outputs at their reset values immediately.
//      With IF_PERF_CNT_EN defined, check the counters after scenario 1 (4 fetches -> perf_fetch_cnt=4).

Source files
------------

// File: rtl/if_stage.sv
// if_stage: instruction-fetch stage and IF/ID pipeline register.
// Owns the PC and fetches from a variable-latency instruction memory through a
// req/ack handshake. At most one request is in flight. A request is never
// withdrawn, so a redirect that arrives while a request is outstanding waits
// in DRAIN for the ack. IF/ID is held on stall and loaded with a bubble on
// flush.
// Optional feature: define IF_PERF_CNT_EN to add saturating fetch/bubble
// performance counters (perf_fetch_cnt, perf_bubble_cnt).
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] branch_target,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instruction,
  output logic        if_id_valid
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_bubble_cnt
`endif
);

  typedef enum logic [1:0] {
    START = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] hold_buf;
  logic [31:0] redir;
  logic [31:0] target;
  logic        deliver;
  logic [31:0] deliver_instr;

  // Redirect targets are always word aligned.
  assign target    = {branch_target[31:2], 2'b00};
  // The PC only moves on an ack or from HOLD, so it is the address in both FETCH and DRAIN.
  assign imem_addr = pc;

  // Decide whether a real instruction reaches IF/ID this cycle and where it comes from.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    deliver       = 1'b0;
    deliver_instr = hold_buf;
    unique case (state)
      FETCH: begin
        deliver       = imem_ack && !stall && !flush;
        deliver_instr = imem_rdata;
      end
      HOLD:    deliver = !stall && !flush;
      default: deliver = 1'b0;
    endcase
  end

  // Fetch FSM: PC, request line and the side buffers for stalled data and pending redirects.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      state    <= START;
      pc       <= RESET_PC;
      hold_buf <= '0;
      redir    <= '0;
      imem_req <= 1'b0;
    end else begin
      unique case (state)
        START: begin
          state    <= FETCH;
          imem_req <= 1'b1;
        end
        FETCH: begin
          if (imem_ack) begin
            if (flush) begin
              pc <= target;
            end else if (!stall) begin
              pc <= pc + 32'd4;
            end else begin
              hold_buf <= imem_rdata;
              state    <= HOLD;
              imem_req <= 1'b0;
            end
          end else if (flush) begin
            redir <= target;
            state <= DRAIN;
          end
        end
        HOLD: begin
          if (flush) begin
            pc       <= target;
            state    <= FETCH;
            imem_req <= 1'b1;
          end else if (!stall) begin
            pc       <= pc + 32'd4;
            state    <= FETCH;
            imem_req <= 1'b1;
          end
        end
        DRAIN: begin
          if (imem_ack) begin
            pc    <= flush ? target : redir;
            state <= FETCH;
          end else if (flush) begin
            redir <= target;
          end
        end
        default: begin
          state    <= START;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

  // IF/ID register: flush beats stall, stall holds, otherwise load an instruction or a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_id_pc          <= '0;
      if_id_instruction <= NOP_INSTR;
      if_id_valid       <= 1'b0;
    end else if (flush) begin
      if_id_pc          <= '0;
      if_id_instruction <= NOP_INSTR;
      if_id_valid       <= 1'b0;
    end else if (!stall) begin
      if (deliver) begin
        if_id_pc          <= pc;
        if_id_instruction <= deliver_instr;
        if_id_valid       <= 1'b1;
      end else begin
        if_id_pc          <= '0;
        if_id_instruction <= NOP_INSTR;
        if_id_valid       <= 1'b0;
      end
    end
  end

`ifdef IF_PERF_CNT_EN
  // Saturating counters of IF/ID loads, split into real instructions and bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_cnt  <= '0;
      perf_bubble_cnt <= '0;
    end else if (flush || !stall) begin
      if (deliver && !flush) begin
        if (perf_fetch_cnt != '1) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      end else begin
        if (perf_bubble_cnt != '1) perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed scenarios followed by randomized stall/flush/latency
// traffic, checked every cycle against a behavioural model of the fetch stage.
module tb_if_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ack;
  logic        stall;
  logic        flush;
  logic [31:0] branch_target;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instruction;
  logic        if_id_valid;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_bubble_cnt;
`endif

  int errors = 0;
  int checks = 0;

  // Behavioural model: what the fetch unit is doing, not how it is encoded.
  logic        m_started;     // first idle cycle after reset is over
  logic        m_held;        // an instruction was returned under stall and waits
  logic [31:0] m_held_data;
  logic        m_redirect;    // a redirect is waiting for the outstanding request
  logic [31:0] m_redirect_pc;
  logic [31:0] m_pc;          // address being (or to be) fetched
  logic [31:0] m_id_pc;
  logic [31:0] m_id_instr;
  logic        m_id_valid;
  int unsigned m_fetches;
  int unsigned m_bubbles;

  // Memory environment
  int          mem_age;
  int          mem_lat;
  bit          rand_lat;
  bit          fixed_data;

  if_stage dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .imem_req          (imem_req),
    .imem_addr         (imem_addr),
    .imem_rdata        (imem_rdata),
    .imem_ack          (imem_ack),
    .stall             (stall),
    .flush             (flush),
    .branch_target     (branch_target),
    .if_id_pc          (if_id_pc),
    .if_id_instruction (if_id_instruction),
    .if_id_valid       (if_id_valid)
`ifdef IF_PERF_CNT_EN
    ,
    .perf_fetch_cnt    (perf_fetch_cnt),
    .perf_bubble_cnt   (perf_bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    if (fixed_data) return 32'h00A0_0093;
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_started = 1'b0; m_held = 1'b0; m_held_data = '0;
    m_redirect = 1'b0; m_redirect_pc = '0; m_pc = 32'h0;
    m_id_pc = '0; m_id_instr = NOP; m_id_valid = 1'b0;
    m_fetches = 0; m_bubbles = 0;
  endtask

  // One clock edge of the model, given the inputs presented in that cycle.
  task automatic model_step(input logic s, input logic f, input logic [31:0] t_raw,
                            input logic ack, input logic [31:0] data);
    logic [31:0] t;
    logic        got;
    logic [31:0] got_pc;
    logic [31:0] got_instr;
    t = t_raw & 32'hFFFF_FFFC;
    got = 1'b0; got_pc = m_pc; got_instr = '0;
    if (!m_started) begin
      m_started = 1'b1;
    end else if (m_held) begin
      if (f) begin
        m_held = 1'b0; m_pc = t;
      end else if (!s) begin
        got = 1'b1; got_instr = m_held_data; m_held = 1'b0; m_pc = m_pc + 4;
      end
    end else if (m_redirect) begin
      if (ack) begin
        m_pc = f ? t : m_redirect_pc; m_redirect = 1'b0;
      end else if (f) begin
        m_redirect_pc = t;
      end
    end else begin
      if (ack) begin
        if (f) m_pc = t;
        else if (!s) begin got = 1'b1; got_instr = data; m_pc = m_pc + 4; end
        else begin m_held = 1'b1; m_held_data = data; end
      end else if (f) begin
        m_redirect = 1'b1; m_redirect_pc = t;
      end
    end
    if (f) begin
      m_id_pc = '0; m_id_instr = NOP; m_id_valid = 1'b0; m_bubbles++;
    end else if (!s) begin
      if (got) begin
        m_id_pc = got_pc; m_id_instr = got_instr; m_id_valid = 1'b1; m_fetches++;
      end else begin
        m_id_pc = '0; m_id_instr = NOP; m_id_valid = 1'b0; m_bubbles++;
      end
    end
  endtask

  // Called at a falling edge: compare, drive this cycle's inputs, advance model, wait a cycle.
  task automatic step(input logic s, input logic f, input logic [31:0] t);
    logic        ack;
    logic [31:0] data;
    logic        exp_req;
    exp_req = m_started && !m_held;
    check("if_id_pc", if_id_pc, m_id_pc);
    check("if_id_instruction", if_id_instruction, m_id_instr);
    check("if_id_valid", {31'b0, if_id_valid}, {31'b0, m_id_valid});
    check("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
    if (exp_req) check("imem_addr", imem_addr, m_pc);
    ack  = imem_req && (mem_age >= mem_lat);
    data = ack ? mem_data(imem_addr) : $urandom;
    stall = s; flush = f; branch_target = t; imem_ack = ack; imem_rdata = data;
    model_step(s, f, t, ack, data);
    if (ack) begin
      mem_age = 0;
      if (rand_lat) mem_lat = $urandom_range(0, 3);
    end else if (imem_req) begin
      mem_age++;
    end
    @(negedge clk);
  endtask

  // Assert reset at a falling edge, check outputs at once, release a cycle later.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_if_id_pc", if_id_pc, 32'h0);
    check("rst_if_id_instruction", if_id_instruction, NOP);
    check("rst_if_id_valid", {31'b0, if_id_valid}, 32'h0);
    check("rst_imem_req", {31'b0, imem_req}, 32'h0);
`ifdef IF_PERF_CNT_EN
    check("rst_perf_fetch_cnt", perf_fetch_cnt, 32'h0);
    check("rst_perf_bubble_cnt", perf_bubble_cnt, 32'h0);
`endif
    stall = 1'b0; flush = 1'b0; imem_ack = 1'b0; imem_rdata = '0; branch_target = '0;
    mem_age = 0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; imem_ack = 1'b0;
    imem_rdata = '0; branch_target = '0;
    mem_age = 0; mem_lat = 0; rand_lat = 1'b0; fixed_data = 1'b1;
    model_reset();
    @(negedge clk);
    do_reset();

    // Single-cycle ack, fixed data: four consecutive accepts 0,4,8,C.
    repeat (5) step(1'b0, 1'b0, '0);
    check("s1_last_pc", if_id_pc, 32'hC);
    check("s1_last_instr", if_id_instruction, 32'h00A0_0093);
`ifdef IF_PERF_CNT_EN
    check("s1_perf_fetch_cnt", perf_fetch_cnt, 32'd4);
    check("s1_perf_bubble_cnt", perf_bubble_cnt, m_bubbles);
`endif

    // Three-cycle ack latency: bubbles while waiting, address stable.
    fixed_data = 1'b0;
    mem_lat = 3;
    repeat (12) step(1'b0, 1'b0, '0);

    // Stall for two cycles coinciding with the ack at pc=8.
    do_reset();
    mem_lat = 0;
    repeat (3) step(1'b0, 1'b0, '0);
    step(1'b1, 1'b0, '0);
    step(1'b1, 1'b0, '0);
    check("s3_hold_pc", if_id_pc, 32'h4);
    mem_lat = 3;
    step(1'b0, 1'b0, '0);
    check("s3_release_pc", if_id_pc, 32'h8);
    check("s3_release_valid", {31'b0, if_id_valid}, 32'h1);
    check("s3_next_addr", imem_addr, 32'hC);

    // Flush to 0x40 while the request for 0xC is outstanding.
    step(1'b0, 1'b1, 32'h40);
    check("s4_drain_addr", imem_addr, 32'hC);
    repeat (3) step(1'b0, 1'b0, '0);
    check("s4_redirect_addr", imem_addr, 32'h40);
    check("s4_bubble_valid", {31'b0, if_id_valid}, 32'h0);
    check("s4_bubble_instr", if_id_instruction, NOP);

    // Flush and stall together, ack in the same cycle; unaligned target.
    mem_lat = 0;
    step(1'b0, 1'b0, '0);
    check("s5_pre_valid", {31'b0, if_id_valid}, 32'h1);
    step(1'b1, 1'b1, 32'h83);
    check("s5_flush_wins_valid", {31'b0, if_id_valid}, 32'h0);
    check("s5_target_addr", imem_addr, 32'h80);

    // PC wrap from the top of the address space.
    step(1'b0, 1'b1, 32'hFFFF_FFFE);
    step(1'b0, 1'b0, '0);
    check("wrap_if_id_pc", if_id_pc, 32'hFFFF_FFFC);
    check("wrap_next_addr", imem_addr, 32'h0);

    // Reset asserted while draining.
    mem_lat = 3;
    step(1'b0, 1'b1, 32'h100);
    step(1'b0, 1'b0, '0);
    do_reset();

    // Randomized traffic.
    rand_lat = 1'b1;
    mem_lat = $urandom_range(0, 3);
    for (int i = 0; i < 2000; i++) begin
      logic        s;
      logic        f;
      logic [31:0] t;
      s = ($urandom_range(0, 3) == 0);
      f = ($urandom_range(0, 9) == 0);
      t = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : $urandom;
      if ($urandom_range(0, 299) == 0) do_reset();
      else step(s, f, t);
    end
`ifdef IF_PERF_CNT_EN
    check("rand_perf_fetch_cnt", perf_fetch_cnt, m_fetches);
    check("rand_perf_bubble_cnt", perf_bubble_cnt, m_bubbles);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
